puf_challenge_sequencer: RTL and testbench
==========================================

# puf_challenge_sequencer

Controller that drives the arbiter PUF delay chain through one complete challenge-response evaluation. It accepts an N-bit challenge over a valid/ready handshake, then repeats the cycle clear latch, launch edge, wait for the race to settle, sample response VOTES times. It majority-votes the samples and returns the response bit plus a stability flag over a second valid/ready handshake. It sits between the system request logic and the PUF chain: it owns the chain's select bus, its launch input and its latch reset.

## Interface
Parameters:
- N, 128, challenge width; equals the PUF stage count.
- SETTLE_CYCLES, 16, cycles launch is held before sampling; must be >= 2 to cover the synchronizer.
- VOTES, 7, evaluations per challenge; must be odd and >= 1.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high.
- req_valid, in, 1, challenge request present.
- req_ready, out, 1, sequencer can accept a challenge.
- req_challenge, in, N, challenge; captured on handshake.
- puf_sel, out, N, registered select bus to the PUF stages.
- puf_in, out, 1, launch signal to the chain input; a rising edge starts a race.
- puf_reset, out, 1, clear for the PUF response latch.
- puf_out, in, 1, asynchronous latch output from the PUF.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, consumer accepts the response.
- rsp_bit, out, 1, majority response.
- rsp_ones, out, $clog2(VOTES+1), count of samples equal to 1.
- rsp_unstable, out, 1, set when the samples were not unanimous.
- busy, out, 1, high in any state other than IDLE.

## Operation
- States: IDLE, CLEAR, LAUNCH, SETTLE, SAMPLE, DONE.
- puf_out passes through a 2-flop synchronizer before any use.
- IDLE
  - req_ready=1, puf_reset=1, puf_in=0.
  - On req_valid&&req_ready: puf_sel<=req_challenge, vote_cnt<=0, ones<=0; go to CLEAR.
- CLEAR (1 cycle)
  - puf_reset=1, puf_in=0; go to LAUNCH.
- LAUNCH (1 cycle)
  - puf_reset=0, puf_in=1, settle_cnt<=0; go to SETTLE.
- SETTLE (SETTLE_CYCLES cycles)
  - puf_reset=0, puf_in=1.
  - When settle_cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (1 cycle)
  - puf_in=1, puf_reset=0.
  - ones<=ones+sync_out; vote_cnt<=vote_cnt+1.
  - If vote_cnt==VOTES-1, go to DONE; otherwise go to CLEAR.
- DONE
  - rsp_valid=1.
  - rsp_bit=(ones>VOTES/2); rsp_ones=ones.
  - rsp_unstable=(ones!=0 && ones!=VOTES).
  - puf_reset=1, puf_in=0.
  - On rsp_ready, go to IDLE.
- Held-output rules:
  - puf_sel changes only on request acceptance; it holds across all votes and after DONE.
  - req_challenge is ignored outside IDLE.
  - rsp_bit, rsp_ones and rsp_unstable are registered. They remain stable while rsp_valid=1 and hold their last values after the handshake.
- Arithmetic: ones and vote_cnt never exceed VOTES, so no wrap is possible; counters are sized to $clog2(VOTES+1).

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE.
  - puf_sel=0, puf_in=0, puf_reset=1.
  - rsp_valid=0, rsp_bit=0, rsp_ones=0, rsp_unstable=0, busy=0.
  - req_ready=1 from the first cycle after reset deasserts.
- One vote takes SETTLE_CYCLES+3 cycles.
- Latency: rsp_valid rises exactly VOTES*(SETTLE_CYCLES+3) clock edges after the accepting edge. With defaults this is 133 cycles.
- Back-to-back requests: after the rsp handshake edge, req_ready=1 on the next cycle. No request is accepted in the same cycle as the response handshake.
- rsp_valid is held indefinitely while rsp_ready=0, and the PUF stays cleared during that time.
- Reset mid-operation returns to IDLE, discards partial votes and produces no response.
- req_valid held high while busy causes no acceptance and no change to puf_sel.

## Test plan
Bench parameters: N=8, SETTLE_CYCLES=4, VOTES=3, so one vote is 7 cycles and a full evaluation is 21 cycles.
- Reset idle: after reset, req_ready=1, puf_reset=1, puf_in=0, puf_sel=0x00 and rsp_valid=0.
- Stable 1: request 0xA5 with the PUF model always returning 1. Required: puf_sel=0xA5; three puf_in rising edges 7 cycles apart; rsp_valid exactly 21 edges after acceptance; rsp_bit=1, rsp_ones=3, rsp_unstable=0.
- Noisy: model returns 1,0,1. Required: rsp_bit=1, rsp_ones=2, rsp_unstable=1. With sequence 0,0,1: rsp_bit=0, rsp_ones=1, rsp_unstable=1.
- Backpressure: hold rsp_ready=0 for 10 cycles. Required: rsp_valid and rsp outputs stay constant and req_ready=0; a second request 0x3C is not accepted until the cycle after rsp_ready=1.
- Mid-run reset: assert reset during the second SETTLE. Required: immediate IDLE values, no rsp_valid; a new request then completes normally in 21 cycles.
- Per-vote waveform: check puf_reset=1 in the CLEAR cycle and puf_in low for exactly one cycle between votes.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: runs VOTES clear/launch/settle/sample rounds
// per challenge and returns the majority-voted response with a stability flag.
module puf_challenge_sequencer #(
  parameter int N             = 128,
  parameter int SETTLE_CYCLES = 16,
  parameter int VOTES         = 7,
  localparam int CW = $clog2(VOTES + 1),
  localparam int SW = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [N-1:0]  req_challenge,
  output logic [N-1:0]  puf_sel,
  output logic          puf_in,
  output logic          puf_reset,
  input  logic          puf_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_bit,
  output logic [CW-1:0] rsp_ones,
  output logic          rsp_unstable,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, SETTLE, SAMPLE, DONE} state_t;

  state_t          state, next_state;
  logic            launch_d, clear_d;
  logic [SW-1:0]   settle_cnt;
  logic [CW-1:0]   vote_cnt;
  logic [CW-1:0]   ones;
  logic [CW-1:0]   ones_next;
  logic            sync_p0, sync_p1;
  logic            last_vote;

  function automatic logic majority(input logic [CW-1:0] cnt);
    return cnt > CW'(VOTES / 2);
  endfunction

  function automatic logic split_vote(input logic [CW-1:0] cnt);
    return (cnt != '0) && (cnt != CW'(VOTES));
  endfunction

  // p0 -> p1: two-flop synchronizer on the asynchronous latch output
  always_ff @(posedge clk) begin
    sync_p0 <= puf_out;
    sync_p1 <= sync_p0;
  end

  assign ones_next = ones + CW'(sync_p1);
  assign last_vote = (vote_cnt == CW'(VOTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      puf_in    <= 1'b0;
      puf_reset <= 1'b1;
    end else begin
      state     <= next_state;
      puf_in    <= launch_d;
      puf_reset <= clear_d;
    end
  end

  // Chain drives are registered from next_state so they line up with the state and never glitch.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) next_state = CLEAR;
      end
      CLEAR:  next_state = LAUNCH;
      LAUNCH: next_state = SETTLE;
      SETTLE: if (settle_cnt == SW'(SETTLE_CYCLES - 1)) next_state = SAMPLE;
      SAMPLE: next_state = last_vote ? DONE : CLEAR;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    launch_d = (next_state == LAUNCH) || (next_state == SETTLE) || (next_state == SAMPLE);
    clear_d  = !launch_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      puf_sel      <= '0;
      settle_cnt   <= '0;
      vote_cnt     <= '0;
      ones         <= '0;
      rsp_bit      <= 1'b0;
      rsp_ones     <= '0;
      rsp_unstable <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        puf_sel  <= req_challenge;
        vote_cnt <= '0;
        ones     <= '0;
      end
      if (state == LAUNCH) settle_cnt <= '0;
      else if (state == SETTLE) settle_cnt <= settle_cnt + SW'(1);
      // Response registers load once, on the final sample, then hold through DONE and beyond.
      if (state == SAMPLE) begin
        ones     <= ones_next;
        vote_cnt <= vote_cnt + CW'(1);
        if (last_vote) begin
          rsp_bit      <= majority(ones_next);
          rsp_ones     <= ones_next;
          rsp_unstable <= split_vote(ones_next);
        end
      end
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer with a behavioural PUF latch model
// returning a chosen bit per launch.
module tb_puf_challenge_sequencer;

  localparam int N      = 8;
  localparam int SETTLE = 4;
  localparam int VOTES  = 3;
  localparam int CW     = 2;
  localparam int EVAL   = VOTES * (SETTLE + 3);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [N-1:0]  req_challenge = '0;
  logic [N-1:0]  puf_sel;
  logic          puf_in;
  logic          puf_reset;
  logic          puf_out;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_bit;
  logic [CW-1:0] rsp_ones;
  logic          rsp_unstable;
  logic          busy;

  typedef struct {
    logic [N-1:0]  sel;
    logic          bitv;
    logic [CW-1:0] ones;
    logic          unst;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   launch_cnt = 0;
  int   base_cnt = 0;
  int   pidx;
  logic [VOTES-1:0] votes_pat = '0;

  puf_challenge_sequencer #(.N(N), .SETTLE_CYCLES(SETTLE), .VOTES(VOTES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_challenge(req_challenge),
    .puf_sel(puf_sel), .puf_in(puf_in), .puf_reset(puf_reset), .puf_out(puf_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bit(rsp_bit),
    .rsp_ones(rsp_ones), .rsp_unstable(rsp_unstable), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge puf_in) launch_cnt <= launch_cnt + 1;

  // PUF latch: after the k-th launch of a request it resolves to votes_pat[k]; cleared by puf_reset.
  always_comb begin
    pidx = launch_cnt - base_cnt - 1;
    puf_out = 1'b0;
    if (puf_in && !puf_reset && pidx >= 0 && pidx < VOTES) puf_out = votes_pat[pidx];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] ch, input logic [VOTES-1:0] pat);
    exp_t e;
    int k;
    k = 0;
    for (int i = 0; i < VOTES; i++) k += int'(pat[i]);
    e.sel  = ch;
    e.ones = CW'(k);
    e.bitv = (2 * k > VOTES);
    e.unst = (k != 0) && (k != VOTES);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] ch, input logic [VOTES-1:0] pat);
    int n;
    votes_pat = pat;
    base_cnt  = launch_cnt;
    exp_q.push_back(model(ch, pat));
    req_challenge = ch;
    req_valid     = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    chk("req_ready_timeout", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("sel_after_accept", puf_sel, ch);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || rsp_valid) && n < 100) begin tick(); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic monitor();
    logic prev_valid, prev_in, in_flight;
    int accept_cyc, rise_idx, low_cnt, last_rise;
    logic h_bit, h_unst;
    logic [CW-1:0] h_ones;
    exp_t e;
    prev_valid = 0; prev_in = 0; in_flight = 0;
    accept_cyc = 0; rise_idx = 0; low_cnt = 0; last_rise = 0;
    h_bit = 0; h_unst = 0; h_ones = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 0; prev_in = 0; in_flight = 0;
      end else begin
        if (prev_valid) begin
          chk("rsp_bit_hold", rsp_bit, h_bit);
          chk("rsp_ones_hold", rsp_ones, h_ones);
          chk("rsp_unstable_hold", rsp_unstable, h_unst);
        end
        if (rsp_valid) begin
          chk("req_ready_in_done", req_ready, 0);
          chk("puf_cleared_in_done", puf_reset, 1);
        end
        if (rsp_valid && !prev_valid) begin
          chk("latency", cyc - accept_cyc, EVAL);
          chk("launch_count", rise_idx, VOTES);
          h_bit = rsp_bit; h_ones = rsp_ones; h_unst = rsp_unstable;
        end
        if (in_flight) begin
          if (puf_in && !prev_in) begin
            if (rise_idx > 0) begin
              chk("launch_spacing", cyc - last_rise, SETTLE + 3);
              chk("low_between_votes", low_cnt, 1);
            end
            rise_idx++;
            low_cnt = 0;
            last_rise = cyc;
          end
          if (!puf_in) begin
            low_cnt++;
            chk("puf_reset_when_low", puf_reset, 1);
          end else begin
            chk("puf_reset_when_launched", puf_reset, 0);
          end
        end
        if (rsp_valid && rsp_ready) begin
          chk("rsp_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rsp_bit", rsp_bit, e.bitv);
            chk("rsp_ones", rsp_ones, e.ones);
            chk("rsp_unstable", rsp_unstable, e.unst);
            chk("rsp_sel", puf_sel, e.sel);
          end
          in_flight = 0;
        end
        if (req_valid && req_ready) begin
          in_flight = 1;
          accept_cyc = cyc + 1;
          rise_idx = 0;
          low_cnt = 0;
        end
        prev_valid = rsp_valid;
        prev_in = puf_in;
      end
    end
  endtask

  initial begin
    int n;
    logic seen;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_puf_reset", puf_reset, 1);
    chk("reset_puf_in", puf_in, 0);
    chk("reset_puf_sel", puf_sel, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_ones", rsp_ones, 0);
    fork
      monitor();
    join_none
    tick();

    // stable one, then two noisy patterns (vote order is bit 0 first)
    rsp_ready = 1'b1;
    issue(8'hA5, 3'b111); wait_idle();
    issue(8'h11, 3'b101); wait_idle();
    issue(8'h22, 3'b100); wait_idle();

    // backpressure with a second request held pending
    rsp_ready = 1'b0;
    issue(8'h5A, 3'b010);
    req_challenge = 8'h3C;
    req_valid = 1'b1;
    n = 0;
    while (!rsp_valid && n < 100) begin
      chk("sel_hold_busy", puf_sel, 8'h5A);
      tick(); n++;
    end
    chk("rsp_timeout", rsp_valid, 1);
    votes_pat = 3'b011;
    base_cnt = launch_cnt;
    exp_q.push_back(model(8'h3C, 3'b011));
    repeat (10) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_sel", puf_sel, 8'h5A);
      chk("bp_puf_in", puf_in, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("b2b_ready_after_hs", req_ready, 1);
    chk("b2b_not_accepted_at_hs", puf_sel, 8'h5A);
    tick();
    req_valid = 1'b0;
    chk("b2b_sel", puf_sel, 8'h3C);
    chk("b2b_busy", busy, 1);
    wait_idle();

    // reset during the second SETTLE
    issue(8'h77, 3'b111);
    n = 0;
    while ((launch_cnt - base_cnt) < 2 && n < 100) begin tick(); n++; end
    chk("second_launch_timeout", launch_cnt - base_cnt, 2);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_puf_in", puf_in, 0);
    chk("mid_reset_puf_reset", puf_reset, 1);
    chk("mid_reset_puf_sel", puf_sel, 0);
    chk("mid_reset_rsp_valid", rsp_valid, 0);
    chk("mid_reset_req_ready", req_ready, 1);
    exp_q.delete();
    tick();
    reset = 1'b0;
    seen = 1'b0;
    repeat (EVAL + 5) begin tick(); seen = seen | rsp_valid; end
    chk("no_rsp_after_reset", seen, 0);
    issue(8'hC3, 3'b001); wait_idle();

    // randomized requests with random response backpressure
    for (int t = 0; t < 12; t++) begin
      logic [N-1:0] ch;
      logic [VOTES-1:0] pat;
      int d;
      ch  = N'($urandom_range(0, 255));
      pat = VOTES'($urandom_range(0, 7));
      d   = $urandom_range(0, 3);
      rsp_ready = (d == 0);
      issue(ch, pat);
      wait_rsp();
      repeat (d) tick();
      rsp_ready = 1'b1;
      wait_idle();
    end

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
